// File: rtl/sy_tohost_pkg.sv
// Shared types and constants for the tohost write-back monitor.
package sy_tohost_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } tohost_state_e;

  localparam logic [63:0] TOHOST_ADDR_DFLT = 64'h8000_1000;
  localparam logic [63:0] PASS_CODE        = 64'd1;

endpackage

// File: rtl/sy_sat_cnt.sv
// Up-counter with synchronous clear and increment enable that sticks at all-ones.
module sy_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                         r_cnt <= '0;
    else if (clr_i)                     r_cnt <= '0;
    else if (inc_i && (r_cnt != '1))    r_cnt <= r_cnt + W'(1);
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/sy_tohost_mon.sv
// Watches LSU stores to the tohost address and latches the test verdict (pass/fail/timeout).
module sy_tohost_mon
  import sy_tohost_pkg::*;
#(
  parameter int unsigned AWTH    = 64,
  parameter int unsigned DWTH    = 64,
  parameter int unsigned TMO_CYC = 32'd1_000_000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [AWTH-1:0] tohost_addr_i,
  input  logic            st_vld_i,
  input  logic            st_rdy_i,
  input  logic            st_we_i,
  input  logic [AWTH-1:0] st_paddr_i,
  input  logic [DWTH-1:0] st_data_i,
  output logic            done_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic            tmo_o,
  output logic [DWTH-1:0] result_o,
  output logic [DWTH-2:0] fail_id_o,
  output logic [63:0]     cyc_cnt_o,
  output logic [15:0]     nterm_cnt_o
);

  tohost_state_e   r_state, w_state_nxt;
  logic            r_pass, r_fail, r_tmo;
  logic            w_pass_d, w_fail_d, w_tmo_d;
  logic [DWTH-1:0] r_result;
  logic [63:0]     w_cyc_cnt;
  logic            w_in_run, w_hit, w_term, w_is_pass, w_tmo_lim, w_arm;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_arm     = (r_state == ST_IDLE) && en_i;
  assign w_hit     = st_vld_i && st_rdy_i && st_we_i && (st_paddr_i == tohost_addr_i);
  assign w_term    = w_in_run && w_hit && st_data_i[0];
  assign w_is_pass = (st_data_i == DWTH'(PASS_CODE));
  assign w_tmo_lim = (w_cyc_cnt == (64'(TMO_CYC) - 64'd1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_tmo    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pass  <= w_pass_d;
      r_fail  <= w_fail_d;
      r_tmo   <= w_tmo_d;
      if (w_term) r_result <= st_data_i;
    end
  end

  // A terminal hit on the limit cycle takes priority over the timeout.
  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en_i) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_term)         w_state_nxt = w_is_pass ? ST_PASS : ST_FAIL;
        else if (w_tmo_lim) w_state_nxt = ST_TMO;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    w_pass_d = (w_state_nxt == ST_PASS);
    w_fail_d = (w_state_nxt == ST_FAIL);
    w_tmo_d  = (w_state_nxt == ST_TMO);
  end

  sy_sat_cnt #(.W(64)) u_cyc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_arm),
    .inc_i (w_in_run),
    .cnt_o (w_cyc_cnt)
  );

  sy_sat_cnt #(.W(16)) u_nterm_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_arm),
    .inc_i (w_in_run && w_hit && !st_data_i[0]),
    .cnt_o (nterm_cnt_o)
  );

  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign tmo_o     = r_tmo;
  assign done_o    = r_pass | r_fail | r_tmo;
  assign result_o  = r_result;
  assign fail_id_o = r_result[DWTH-1:1];
  assign cyc_cnt_o = w_cyc_cnt;

endmodule
